// File: rtl/rvfi_pkg.sv
// Shared types for the RVFI retirement tracker: shadow-stage entry, output record, order width.
// Struct widths are the core's XLEN/ILEN; the tracker's width parameters must keep these values.
package rvfi_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;
  localparam int ORDER_W  = 64;
  localparam int RD_W     = 5;

  typedef struct packed {
    logic                valid;
    logic [ILEN_DEF-1:0] insn;
    logic [XLEN_DEF-1:0] pc;
  } rvfi_stage_t;

  typedef struct packed {
    logic                valid;
    logic [ORDER_W-1:0]  order;
    logic [ILEN_DEF-1:0] insn;
    logic [XLEN_DEF-1:0] pc_rdata;
    logic [XLEN_DEF-1:0] pc_wdata;
    logic [RD_W-1:0]     rd_addr;
    logic [XLEN_DEF-1:0] rd_wdata;
    logic                trap;
  } rvfi_retire_t;

  // x0 writes are architecturally invisible, so the record reports 0
  function automatic logic [XLEN_DEF-1:0] rd_wdata_filt(input logic [RD_W-1:0]     addr,
                                                         input logic [XLEN_DEF-1:0] wdata);
    return (addr == '0) ? '0 : wdata;
  endfunction

endpackage

// File: rtl/rvfi_pipe_stage.sv
// One shadow pipeline stage: loads from upstream when not stalled, holds when stalled.
// A kill drops the current occupant either in place (stall) or on its way downstream (shift).
module rvfi_pipe_stage
  import rvfi_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_kill,
  input  rvfi_stage_t i_in,
  output rvfi_stage_t o_q,
  output logic        o_fwd_valid
);

  rvfi_stage_t stage_q;
  rvfi_stage_t stage_d;

  always_comb begin
    stage_d = stage_q;
    if (i_stall) begin
      stage_d.valid = stage_q.valid & ~i_kill;
    end else begin
      stage_d = i_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_q         = stage_q;
  assign o_fwd_valid = stage_q.valid & ~i_kill;

endmodule

// File: rtl/rvfi_retire_tracker.sv
// RVFI retirement tracker: shadows issued insn/PC through STAGES stages, emits one registered
// record per commit with a contiguous 64-bit order. Issue-to-rvfi_valid latency is STAGES+1 cycles.
module rvfi_retire_tracker
  import rvfi_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int XLEN   = XLEN_DEF,
  parameter int ILEN   = ILEN_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_issue_valid,
  input  logic [ILEN-1:0]              i_issue_insn,
  input  logic [XLEN-1:0]              i_issue_pc,
  input  logic                         i_stall,
  input  logic [STAGES-1:0]            i_flush_mask,
  input  logic [4:0]                   i_wb_rd_addr,
  input  logic [XLEN-1:0]              i_wb_rd_wdata,
  input  logic [XLEN-1:0]              i_wb_pc_wdata,
  input  logic                         i_wb_trap,
  output logic                         rvfi_valid,
  output logic [63:0]                  rvfi_order,
  output logic [ILEN-1:0]              rvfi_insn,
  output logic [XLEN-1:0]              rvfi_pc_rdata,
  output logic [XLEN-1:0]              rvfi_pc_wdata,
  output logic [4:0]                   rvfi_rd_addr,
  output logic [XLEN-1:0]              rvfi_rd_wdata,
  output logic                         rvfi_trap,
  output logic [$clog2(STAGES+1)-1:0]  o_inflight
);

  localparam int INF_W = $clog2(STAGES + 1);

  rvfi_stage_t        stage_in [STAGES];
  rvfi_stage_t        stage_q  [STAGES];
  logic [STAGES-1:0]  fwd_vld;
  logic               retire;
  rvfi_retire_t       rec_q;
  rvfi_retire_t       rec_d;
  logic [ORDER_W-1:0] next_order_q;
  logic [ORDER_W-1:0] next_order_d;
  logic [INF_W-1:0]   inflight;

  assign stage_in[0] = '{valid: i_issue_valid, insn: i_issue_insn, pc: i_issue_pc};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stage_in[k] = '{valid: fwd_vld[k-1], insn: stage_q[k-1].insn, pc: stage_q[k-1].pc};
    end
    rvfi_pipe_stage u_stage (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_stall     (i_stall),
      .i_kill      (i_flush_mask[k]),
      .i_in        (stage_in[k]),
      .o_q         (stage_q[k]),
      .o_fwd_valid (fwd_vld[k])
    );
  end

  // A surviving retire-stage occupant commits only on a cycle the pipeline advances
  assign retire = ~i_stall & fwd_vld[STAGES-1];

  always_comb begin
    rec_d        = rec_q;
    rec_d.valid  = 1'b0;
    next_order_d = next_order_q;
    if (retire) begin
      rec_d = '{valid:    1'b1,
                order:    next_order_q,
                insn:     stage_q[STAGES-1].insn,
                pc_rdata: stage_q[STAGES-1].pc,
                pc_wdata: i_wb_pc_wdata,
                rd_addr:  i_wb_rd_addr,
                rd_wdata: rd_wdata_filt(i_wb_rd_addr, i_wb_rd_wdata),
                trap:     i_wb_trap};
      next_order_d = next_order_q + ORDER_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rec_q        <= '0;
      next_order_q <= '0;
    end else begin
      rec_q        <= rec_d;
      next_order_q <= next_order_d;
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < STAGES; k++) begin
      inflight = inflight + INF_W'(stage_q[k].valid);
    end
  end

  assign o_inflight    = inflight;
  assign rvfi_valid    = rec_q.valid;
  assign rvfi_order    = rec_q.order;
  assign rvfi_insn     = rec_q.insn;
  assign rvfi_pc_rdata = rec_q.pc_rdata;
  assign rvfi_pc_wdata = rec_q.pc_wdata;
  assign rvfi_rd_addr  = rec_q.rd_addr;
  assign rvfi_rd_wdata = rec_q.rd_wdata;
  assign rvfi_trap     = rec_q.trap;

endmodule
